uart_transmitter_core: RTL
==========================

Name: uart_transmitter_core

Overview:
Serialises bytes from the TX FIFO onto the UART serial output using the line control register format: 5-8 data bits, optional parity, 1/1.5/2 stop bits, and break.
Bit timing comes from the shared 16x baud `enable` strobe, so every bit lasts 16 enable pulses.
The block sits beside the receive path in the UART core and pops the TX FIFO one byte per frame.

Parameters:
FIFO_WIDTH, 8, width of TX FIFO data word
FIFO_COUNTER_W, 5, width of TX FIFO occupancy count

Ports:
clk  input  1  system clock
wb_rst_i  input  1  reset, asynchronous, active-high
lcr  input  8  line control: [1:0] word length 5..8, [2] stop, [3] PE, [4] EP, [5] stick parity, [6] break
enable  input  1  16x baud strobe, one clk wide
tf_count  input  FIFO_COUNTER_W  TX FIFO occupancy
tf_data_in  input  FIFO_WIDTH  TX FIFO head word, combinational from FIFO
tx_reset  input  1  synchronous abort/flush of the transmitter
tf_pop  output  1  one-clk pop strobe to TX FIFO
stx_pad_o  output  1  serial line, idle high
tstate  output  3  current FSM state, for status and the THRE/TEMT logic

Behaviour:
- Reset values (async wb_rst_i): tstate=IDLE, stx_pad_o=1, tf_pop=0, shift register=0, bit counter=0, tick counter=0.
- tx_reset has the same effect as reset, applied synchronously; it overrides every other condition in the same cycle.
- FSM state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- All FSM and counter updates occur only on cycles with enable=1, except that tf_pop is cleared on the next clk regardless of enable.
- IDLE:
  - stx=1.
  - If enable and tf_count!=0: latch tf_data_in into the shift register, compute and latch the parity bit, load the bit counter with word length-1, set tick counter=15, tf_pop=1 for exactly one clk, go to START.
- START: stx=0 for 16 enables. When tick=0 on an enable, go to DATA and reload tick=15.
- DATA:
  - stx = shift[0], LSB first.
  - At tick=0: shift right; if bit counter=0 go to PARITY when PE=1, otherwise to STOP; else decrement the bit counter. Reload tick=15 in both cases.
- Parity bit:
  - Computed over the low N data bits only, where N is the word length; upper bits are ignored.
  - PE=1, stick=0: EP=0 (odd) gives parity=~^data; EP=1 (even) gives parity=^data.
  - Stick parity: EP=0 transmits 1, EP=1 transmits 0.
- PARITY: stx=parity for 16 enables, then go to STOP.
- STOP:
  - stx=1.
  - Length in enables: 16 when lcr[2]=0; 24 when lcr[2]=1 and word length=5 (1.5 stop); 32 when lcr[2]=1 and word length 6-8. A 5-bit tick counter covers these counts.
  - At the end of STOP go to IDLE.
  - Back-to-back frames: if the FIFO is non-empty, IDLE starts the next frame on the next enable. The line stays high for at most one enable period between the stop bit and the next start bit.
- Break: stx_pad_o = serial_bit & ~lcr[6], registered. Break does not stall the FSM; frames keep being popped and clocked out while the line is held low.
- lcr is sampled live. Software changes lcr only while tstate=IDLE; behaviour for a mid-frame change is defined only as "the frame completes with mixed format, no lockup".
- The FSM never pops with tf_count=0, and issues only one pop per frame.
- stx_pad_o is registered, so it changes one clk after the enable that advances the FSM.

Test Plan:
- 8N1 (lcr=0x03), FIFO holds 0xA5, enable every 16 clk: start 0, then 1,0,1,0,0,1,0,1, stop 1; each bit 256 clk; one tf_pop pulse; tstate returns to 0.
- 7E1 (lcr=0x1A), byte 0xD3: data bits 1,1,0,0,1,0,1 (bit 7 dropped); parity bit 0 (four ones, even); one stop bit.
- 5-bit, 1.5 stop (lcr=0x04), byte 0x1F: five 1s, stop held 24 enables; a second queued byte starts within 1 enable after the stop.
- Stick parity, lcr=0x2B (EP=0) then lcr=0x3B (EP=1): parity bit 1 then 0, independent of data 0x00 and 0xFF.
- Break lcr[6]=1 during a frame: stx_pad_o=0 for the whole duration; the FSM still completes and pops; the line returns high after lcr[6] clears.
- Empty FIFO: tf_count=0 gives no tf_pop and stx=1 indefinitely. tx_reset in DATA gives tstate=0 and stx=1 next clk, with no extra pop. wb_rst_i mid-frame gives all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_transmitter_core_if.sv
// TX FIFO side of the UART transmitter: occupancy, head word and pop strobe.
// master = transmitter (consumer), slave = FIFO (producer).
interface uart_transmitter_core_if #(
  parameter int FIFO_WIDTH     = 8,
  parameter int FIFO_COUNTER_W = 5
);
  logic [FIFO_COUNTER_W-1:0] tf_count;
  logic [FIFO_WIDTH-1:0]     tf_data_in;
  logic                      tf_pop;

  modport master (
    input  tf_count,
    input  tf_data_in,
    output tf_pop
  );

  modport slave (
    output tf_count,
    output tf_data_in,
    input  tf_pop
  );
endinterface

// File: rtl/uart_transmitter_core.sv
// UART serialiser: pops one TX FIFO word per frame and shifts it out as
// start / 5-8 data / optional parity / 1, 1.5 or 2 stop bits at 16 enables per bit.
module uart_transmitter_core #(
  parameter int FIFO_WIDTH     = 8,
  parameter int FIFO_COUNTER_W = 5
) (
  input  logic                    clk,
  input  logic                    wb_rst_i,
  input  logic [7:0]              lcr,
  input  logic                    enable,
  input  logic                    tx_reset,
  uart_transmitter_core_if.master tf,
  output logic                    stx_pad_o,
  output logic [2:0]              tstate
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  tx_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [4:0] tick_q, tick_d;
  logic       parity_q, parity_d;
  logic       pop_q, pop_d;
  logic       stx_q, stx_d;

  logic [FIFO_WIDTH-1:0]     head;
  logic [FIFO_COUNTER_W-1:0] count;
  logic [7:0]                data_mask;
  logic                      raw_parity;
  logic                      parity_calc;
  logic [4:0]                stop_last;
  logic                      serial_bit;
  logic                      unused_lcr;

  assign head       = tf.tf_data_in;
  assign count      = tf.tf_count;
  assign unused_lcr = lcr[7];

  // Format decode; the stop count is loaded minus one so tick=0 marks the last enable.
  always_comb begin
    data_mask  = 8'hFF >> (2'd3 - lcr[1:0]);
    raw_parity = ^(head[7:0] & data_mask);
    if (lcr[5])
      parity_calc = ~lcr[4];
    else if (lcr[4])
      parity_calc = raw_parity;
    else
      parity_calc = ~raw_parity;
    if (!lcr[2])
      stop_last = 5'd15;
    else if (lcr[1:0] == 2'd0)
      stop_last = 5'd23;
    else
      stop_last = 5'd31;
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    tick_d     = tick_q;
    parity_d   = parity_q;
    pop_d      = 1'b0;
    serial_bit = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (enable && count != '0) begin
          shift_d   = head[7:0];
          parity_d  = parity_calc;
          bit_cnt_d = {1'b1, lcr[1:0]};
          tick_d    = 5'd15;
          pop_d     = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        serial_bit = 1'b0;
        if (enable) begin
          if (tick_q == 5'd0) begin
            state_d = S_DATA;
            tick_d  = 5'd15;
          end else begin
            tick_d = tick_q - 5'd1;
          end
        end
      end
      S_DATA: begin
        serial_bit = shift_q[0];
        if (enable) begin
          if (tick_q == 5'd0) begin
            shift_d = {1'b0, shift_q[7:1]};
            tick_d  = 5'd15;
            if (bit_cnt_q == 3'd0) begin
              if (lcr[3]) begin
                state_d = S_PARITY;
              end else begin
                state_d = S_STOP;
                tick_d  = stop_last;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end else begin
            tick_d = tick_q - 5'd1;
          end
        end
      end
      S_PARITY: begin
        serial_bit = parity_q;
        if (enable) begin
          if (tick_q == 5'd0) begin
            state_d = S_STOP;
            tick_d  = stop_last;
          end else begin
            tick_d = tick_q - 5'd1;
          end
        end
      end
      S_STOP: begin
        if (enable) begin
          if (tick_q == 5'd0)
            state_d = S_IDLE;
          else
            tick_d = tick_q - 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Break forces the line low without stalling the frame sequencing.
    stx_d = serial_bit & ~lcr[6];
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tick_q    <= '0;
      parity_q  <= 1'b0;
      pop_q     <= 1'b0;
      stx_q     <= 1'b1;
    end else if (tx_reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tick_q    <= '0;
      parity_q  <= 1'b0;
      pop_q     <= 1'b0;
      stx_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tick_q    <= tick_d;
      parity_q  <= parity_d;
      pop_q     <= pop_d;
      stx_q     <= stx_d;
    end
  end

  assign tf.tf_pop = pop_q;
  assign stx_pad_o = stx_q;
  assign tstate    = state_q;

endmodule
